// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver: buffers ray-tracer pixel beats and re-emits them as AXI4-Stream video with frame geometry checks
module pixel_stream_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [7:0]             in_r,
    input  logic [7:0]             in_g,
    input  logic [7:0]             in_b,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic                   in_eol,
    output logic                   in_ready,
    input  logic [12:0]            image_width,
    input  logic [12:0]            image_height,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   err_clear,
    output logic                   err_sof_unexpected,
    output logic                   err_eol_early,
    output logic                   err_eol_missing,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [FRAME_CNT_W-1:0] drop_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [0:0] S_WAIT_SOF = 1'b0;
    localparam logic [0:0] S_ACTIVE   = 1'b1;

    logic [25:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;
    logic [0:0]             r_state;
    logic [12:0]            r_x;
    logic [12:0]            r_y;
    logic [12:0]            r_w;
    logic [12:0]            r_h;
    logic                   r_err_sof;
    logic                   r_err_early;
    logic                   r_err_missing;
    logic                   r_frame_done;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic [FRAME_CNT_W-1:0] r_drop_count;

    logic        w_accept;
    logic        w_write;
    logic        w_drop;
    logic        w_pop;
    logic [25:0] w_head;
    logic [12:0] w_wd;
    logic [12:0] w_ht;
    logic [12:0] w_x;
    logic [12:0] w_y;
    logic        w_last_col;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_early;
    logic        w_missing;
    logic        w_sof_err;

    assign in_ready    = (r_count != DEPTH_C);
    assign w_accept    = in_valid & in_ready;
    assign w_write     = w_accept & (in_sof | (r_state == S_ACTIVE));
    assign w_drop      = w_accept & ~in_sof & (r_state == S_WAIT_SOF);
    assign w_pop       = m_axis_tvalid & m_axis_tready;
    assign w_head      = r_mem[r_rptr];
    assign w_wd        = in_sof ? ((image_width == 13'd0) ? 13'd1 : image_width) : r_w;
    assign w_ht        = in_sof ? ((image_height == 13'd0) ? 13'd1 : image_height) : r_h;
    assign w_x         = in_sof ? 13'd0 : r_x;
    assign w_y         = in_sof ? 13'd0 : r_y;
    assign w_last_col  = (w_x == w_wd - 13'd1);
    assign w_line_end  = in_eol | w_last_col;
    assign w_frame_end = w_line_end & (w_y == w_ht - 13'd1);
    assign w_early     = w_write & in_eol & ~w_last_col;
    assign w_missing   = w_write & w_last_col & ~in_eol;
    assign w_sof_err   = w_write & in_sof & (r_state == S_ACTIVE);

    assign m_axis_tvalid      = (r_count != '0);
    assign m_axis_tdata       = {8'h00, w_head[23:0]};
    assign m_axis_tuser       = w_head[25];
    assign m_axis_tlast       = w_head[24];
    assign err_sof_unexpected = r_err_sof;
    assign err_eol_early      = r_err_early;
    assign err_eol_missing    = r_err_missing;
    assign frame_done         = r_frame_done;
    assign frame_count        = r_frame_count;
    assign drop_count         = r_drop_count;

    // elastic buffer: write pointer, read pointer and occupancy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wptr] <= {in_sof, in_eol, in_r, in_g, in_b};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_write) - (AW+1)'(w_pop);
        end
    end

    // geometry tracker: latches frame size on sof and walks x/y over written beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_WAIT_SOF;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= 13'd1;
            r_h     <= 13'd1;
        end else if (w_write) begin
            r_state <= w_frame_end ? S_WAIT_SOF : S_ACTIVE;
            r_w     <= w_wd;
            r_h     <= w_ht;
            r_x     <= w_line_end ? 13'd0 : w_x + 13'd1;
            r_y     <= w_frame_end ? 13'd0 : (w_line_end ? w_y + 13'd1 : w_y);
        end
    end

    // sticky error flags; a new event in the clearing cycle keeps its flag set
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_sof     <= 1'b0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_err_sof     <= (r_err_sof & ~err_clear) | w_sof_err;
            r_err_early   <= (r_err_early & ~err_clear) | w_early;
            r_err_missing <= (r_err_missing & ~err_clear) | w_missing;
        end
    end

    // frame statistics: completion pulse, wrapping frame counter, saturating drop counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_frame_done <= w_write & w_frame_end;
            if (w_write && w_frame_end) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            if (w_drop && r_drop_count != '1) r_drop_count <= r_drop_count + FRAME_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pixel_stream_receiver.sv
// tb_pixel_stream_receiver: scenario tasks against a beat-level reference model of the pixel receiver
module tb_pixel_stream_receiver;
    localparam int FCW = 16;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [7:0]     in_r = '0, in_g = '0, in_b = '0;
    logic           in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
    logic           in_ready;
    logic [12:0]    image_width = 13'd4, image_height = 13'd2;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic           m_axis_tready = 1'b1;
    logic           err_clear = 1'b0;
    logic           err_sof_unexpected, err_eol_early, err_eol_missing, frame_done;
    logic [FCW-1:0] frame_count, drop_count;

    int total = 0, bad = 0;
    logic [25:0] exp_q[$];
    bit m_in_frame = 0, m_sof = 0, m_early = 0, m_missing = 0, rnd_rdy = 0;
    int m_x = 0, m_y = 0, m_w = 1, m_h = 1, m_frames = 0, m_drops = 0;
    int m_done_exp = 0, m_done_got = 0, n_out = 0, out_err = 0;
    logic [33:0] last_got = '0, last_exp = '0;

    pixel_stream_receiver #(.FIFO_DEPTH(4), .FRAME_CNT_W(FCW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol), .in_ready(in_ready),
        .image_width(image_width), .image_height(image_height),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .err_clear(err_clear), .err_sof_unexpected(err_sof_unexpected),
        .err_eol_early(err_eol_early), .err_eol_missing(err_eol_missing),
        .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    function automatic void model_beat();
        bit last_col;
        if (!m_in_frame && !in_sof) begin
            if (m_drops < 65535) m_drops++;
            return;
        end
        if (in_sof) begin
            if (m_in_frame) m_sof = 1;
            m_w = (image_width == 0) ? 1 : int'(image_width);
            m_h = (image_height == 0) ? 1 : int'(image_height);
            m_x = 0;
            m_y = 0;
            m_in_frame = 1;
        end
        exp_q.push_back({in_sof, in_eol, in_r, in_g, in_b});
        last_col = (m_x == m_w - 1);
        if (in_eol && !last_col) m_early = 1;
        if (last_col && !in_eol) m_missing = 1;
        if (in_eol || last_col) begin
            m_x = 0;
            if (m_y == m_h - 1) begin
                m_frames++;
                m_done_exp++;
                m_in_frame = 0;
                m_y = 0;
            end else m_y++;
        end else m_x++;
    endfunction

    initial forever begin
        @(posedge aclk or negedge aresetn);
        if (!aresetn) begin
            exp_q.delete();
            m_in_frame = 0; m_x = 0; m_y = 0; m_frames = 0; m_drops = 0;
            m_done_exp = 0; m_done_got = 0; m_sof = 0; m_early = 0; m_missing = 0;
        end else begin
            if (frame_done) m_done_got++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    out_err++;
                    last_got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                    last_exp = '1;
                end else begin
                    if (m_axis_tdata !== {8'h00, exp_q[0][23:0]} || m_axis_tuser !== exp_q[0][25] || m_axis_tlast !== exp_q[0][24]) begin
                        out_err++;
                        last_got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                        last_exp = {exp_q[0][25:24], 8'h00, exp_q[0][23:0]};
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (err_clear) begin m_sof = 0; m_early = 0; m_missing = 0; end
            if (in_valid && in_ready) model_beat();
        end
    end

    initial forever begin
        @(negedge aclk);
        if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send(input bit sof, input bit eol);
        int n = 0;
        @(negedge aclk);
        in_valid = 1; in_sof = sof; in_eol = eol;
        {in_r, in_g, in_b} = 24'($urandom);
        while (!in_ready && n < 100) begin @(negedge aclk); n++; end
        if (!in_ready) begin total++; bad++; $display("FAIL send_timeout: in_ready=%0b required 1", in_ready); end
        @(posedge aclk); #1;
        in_valid = 0; in_sof = 0; in_eol = 0;
    endtask

    task automatic send_frame(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) send(x == 0 && y == 0, x == w - 1);
    endtask

    task automatic drain();
        int n = 0;
        rnd_rdy = 0;
        m_axis_tready = 1;
        while (m_axis_tvalid && n < 200) begin @(negedge aclk); n++; end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL drain_timeout: tvalid=%0b required 0", m_axis_tvalid); end
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%0b required=1", in_ready); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got=%0b required=0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got=%h required=0", m_axis_tdata); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count: got=%0d required=0", frame_count); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop_count: got=%0d required=0", drop_count); end
        total++; if ({err_sof_unexpected, err_eol_early, err_eol_missing, frame_done} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got=%b required=0000", {err_sof_unexpected, err_eol_early, err_eol_missing, frame_done}); end
    endtask

    task automatic test_clean_frame();
        int n0 = n_out, d0 = m_done_got;
        out_err = 0;
        image_width = 4; image_height = 2;
        send_frame(4, 2);
        drain();
        total++; if (n_out - n0 !== 8) begin bad++; $display("FAIL clean_beats: got=%0d required=8", n_out - n0); end
        total++; if (out_err !== 0) begin bad++; $display("FAIL clean_data: errors=%0d got=%h required=%h", out_err, last_got, last_exp); end
        total++; if (m_done_got - d0 !== 1) begin bad++; $display("FAIL clean_frame_done: pulses=%0d required=1", m_done_got - d0); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL clean_frame_count: got=%0d required=1", frame_count); end
        total++; if ({err_sof_unexpected, err_eol_early, err_eol_missing} !== 3'b0) begin
            bad++; $display("FAIL clean_errors: got=%b required=000", {err_sof_unexpected, err_eol_early, err_eol_missing}); end
    endtask

    task automatic test_drop();
        int n0 = n_out;
        out_err = 0;
        for (int i = 0; i < 3; i++) send(0, i == 2);
        @(negedge aclk);
        total++; if (drop_count !== 16'(m_drops) || m_drops !== 3) begin bad++; $display("FAIL drop_count: got=%0d required=%0d", drop_count, m_drops); end
        total++; if (in_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL drop_idle: in_ready=%0b tvalid=%0b required 1/0", in_ready, m_axis_tvalid); end
        send_frame(4, 2);
        drain();
        total++; if (n_out - n0 !== 8) begin bad++; $display("FAIL drop_beats: got=%0d required=8", n_out - n0); end
        total++; if (frame_count !== 16'(m_frames)) begin bad++; $display("FAIL drop_frame_count: got=%0d required=%0d", frame_count, m_frames); end
        total++; if (out_err !== 0) begin bad++; $display("FAIL drop_data: errors=%0d got=%h required=%h", out_err, last_got, last_exp); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held = '0;
        int idx = 0, n = 0, n0 = n_out;
        bit acc;
        out_err = 0;
        image_width = 3; image_height = 2;
        rnd_rdy = 0;
        m_axis_tready = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            if (c == 3) held = m_axis_tdata;
            in_valid = (idx < 6); in_sof = (idx == 0); in_eol = (idx % 3 == 2);
            {in_r, in_g, in_b} = 24'($urandom);
            acc = in_valid && in_ready;
            @(posedge aclk);
            if (acc) idx++;
        end
        @(negedge aclk);
        total++; if (idx !== 4) begin bad++; $display("FAIL bp_accepted: got=%0d required=4", idx); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got=%0b required=0", in_ready); end
        total++; if (m_axis_tdata !== held) begin bad++; $display("FAIL bp_stable: got=%h required=%h", m_axis_tdata, held); end
        total++; if (exp_q.size() == 0 || m_axis_tdata[23:0] !== exp_q[0][23:0] || m_axis_tuser !== 1'b1) begin
            bad++; $display("FAIL bp_head: got=%h user=%0b required first beat with user=1", m_axis_tdata, m_axis_tuser); end
        m_axis_tready = 1;
        while (idx < 6 && n < 50) begin
            in_valid = 1; in_sof = 0; in_eol = (idx % 3 == 2);
            {in_r, in_g, in_b} = 24'($urandom);
            acc = in_ready;
            @(posedge aclk);
            if (acc) idx++;
            @(negedge aclk);
            n++;
        end
        in_valid = 0; in_eol = 0;
        drain();
        total++; if (n_out - n0 !== 6) begin bad++; $display("FAIL bp_beats: got=%0d required=6", n_out - n0); end
        total++; if (out_err !== 0) begin bad++; $display("FAIL bp_order: errors=%0d got=%h required=%h", out_err, last_got, last_exp); end
    endtask

    task automatic test_line_errors();
        int f0 = m_frames;
        out_err = 0;
        image_width = 4; image_height = 3;
        send(1, 0); send(0, 0);
        err_clear = 1;
        send(0, 1);
        err_clear = 0;
        @(negedge aclk);
        total++; if (err_eol_early !== 1'b1 || err_eol_missing !== 1'b0) begin
            bad++; $display("FAIL eol_early: early=%0b missing=%0b required 1/0", err_eol_early, err_eol_missing); end
        for (int i = 0; i < 4; i++) send(0, 0);
        @(negedge aclk);
        total++; if (err_eol_missing !== 1'b1) begin bad++; $display("FAIL eol_missing: got=%0b required=1", err_eol_missing); end
        for (int i = 0; i < 4; i++) send(0, i == 3);
        drain();
        total++; if (frame_count !== 16'(f0 + 1)) begin bad++; $display("FAIL eol_frame_count: got=%0d required=%0d", frame_count, f0 + 1); end
        err_clear = 1;
        @(negedge aclk);
        err_clear = 0;
        @(negedge aclk);
        total++; if ({err_eol_early, err_eol_missing} !== 2'b00) begin
            bad++; $display("FAIL err_clear: got=%b required=00", {err_eol_early, err_eol_missing}); end
        total++; if (out_err !== 0) begin bad++; $display("FAIL eol_data: errors=%0d got=%h required=%h", out_err, last_got, last_exp); end
    endtask

    task automatic test_sof_unexpected();
        do_reset();
        out_err = 0;
        image_width = 4; image_height = 2;
        for (int i = 0; i < 5; i++) send(i == 0, i == 3);
        send(1, 0);
        @(negedge aclk);
        total++; if (err_sof_unexpected !== 1'b1) begin bad++; $display("FAIL sof_unexpected: got=%0b required=1", err_sof_unexpected); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL sof_abandon_count: got=%0d required=0", frame_count); end
        for (int i = 1; i < 8; i++) send(0, i == 3 || i == 7);
        drain();
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL sof_frame_count: got=%0d required=1", frame_count); end
        total++; if (out_err !== 0 || exp_q.size() !== 0) begin bad++; $display("FAIL sof_data: errors=%0d left=%0d got=%h required=%h", out_err, exp_q.size(), last_got, last_exp); end
    endtask

    task automatic test_reset_mid_frame();
        image_width = 4; image_height = 2;
        rnd_rdy = 0;
        m_axis_tready = 0;
        send(1, 0); send(0, 0); send(0, 0);
        #2;
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rst_buffered: tvalid=%0b required=1", m_axis_tvalid); end
        aresetn = 0;
        #1;
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_async: tvalid=%0b required=0", m_axis_tvalid); end
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        total++; if (in_ready !== 1'b1 || frame_count !== 16'd0) begin
            bad++; $display("FAIL rst_release: in_ready=%0b frame_count=%0d required 1/0", in_ready, frame_count); end
        m_axis_tready = 1;
        send(0, 1);
        @(negedge aclk);
        total++; if (drop_count !== 16'd1 || m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL rst_drop: drop_count=%0d tvalid=%0b required 1/0", drop_count, m_axis_tvalid); end
    endtask

    task automatic test_random();
        int w, h, n0 = n_out;
        out_err = 0;
        rnd_rdy = 1;
        for (int f = 0; f < 8; f++) begin
            @(negedge aclk);
            image_width = 13'($urandom_range(0, 5));
            image_height = 13'($urandom_range(0, 3));
            w = (image_width == 0) ? 1 : int'(image_width);
            h = (image_height == 0) ? 1 : int'(image_height);
            repeat ($urandom_range(0, 2)) send(0, 1'($urandom_range(0, 1)));
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    send((x == 0 && y == 0) || ($urandom_range(0, 15) == 0), (x == w - 1) ^ ($urandom_range(0, 7) == 0));
                    if ($urandom_range(0, 3) == 0) @(negedge aclk);
                end
        end
        drain();
        total++; if (out_err !== 0 || exp_q.size() !== 0) begin bad++; $display("FAIL rand_data: errors=%0d left=%0d got=%h required=%h", out_err, exp_q.size(), last_got, last_exp); end
        total++; if (n_out == n0) begin bad++; $display("FAIL rand_activity: outputs=%0d required>0", n_out - n0); end
        total++; if (frame_count !== 16'(m_frames)) begin bad++; $display("FAIL rand_frame_count: got=%0d required=%0d", frame_count, m_frames); end
        total++; if (drop_count !== 16'(m_drops)) begin bad++; $display("FAIL rand_drop_count: got=%0d required=%0d", drop_count, m_drops); end
        total++; if (m_done_got !== m_done_exp) begin bad++; $display("FAIL rand_frame_done: pulses=%0d required=%0d", m_done_got, m_done_exp); end
        total++; if ({err_sof_unexpected, err_eol_early, err_eol_missing} !== {m_sof, m_early, m_missing}) begin
            bad++; $display("FAIL rand_errors: got=%b required=%b", {err_sof_unexpected, err_eol_early, err_eol_missing}, {m_sof, m_early, m_missing}); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_drop();
        test_backpressure();
        test_line_errors();
        test_sof_unexpected();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
